// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared types and constants for the RV32I pipeline control.
//   fwd_sel_t  : EX operand source select (register file / WB / MEM)
//   hz_state_t : hazard controller FSM states
//   REG_X0     : index of the hard-wired zero register
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam int REG_X0 = 0;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit -- combinational forwarding comparator for one EX operand.
//   rs            : source register of the operand in EX
//   mem_rd/_write : destination and write-enable of the instruction in MEM
//   wb_rd/_write  : destination and write-enable of the instruction in WB
//   sel           : operand source; MEM wins over WB, x0 is never forwarded
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output fwd_sel_t          sel
);

  logic hit_mem;
  logic hit_wb;

  assign hit_mem = mem_reg_write && (mem_rd != REG_AW'(REG_X0)) && (mem_rd == rs);
  assign hit_wb  = wb_reg_write  && (wb_rd  != REG_AW'(REG_X0)) && (wb_rd  == rs);

  // MEM holds the younger result, so it must shadow WB.
  always_comb begin
    if (hit_mem)     sel = FWD_MEM;
    else if (hit_wb) sel = FWD_WB;
    else             sel = FWD_RF;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencing controller for the 5-stage RV32I core.
//   Inputs : ID/EX/MEM/WB register fields, load/redirect flags, dmem handshake.
//   Outputs: stall_* (hold PC / pipeline regs), flush_if_id, bubble_id_ex,
//            bubble_mem_wb, pc_redirect, fwd_a/fwd_b operand selects,
//            mem_timeout (sticky), stall_cnt/flush_cnt (saturating).
// Priority within a cycle: memory freeze > EX redirect > load-use stall.
// All control outputs and forwarding selects read 0 while rst_n is low.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_req,
  input  logic              dmem_ready,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              stall_id_ex,
  output logic              stall_ex_mem,
  output logic              flush_if_id,
  output logic              bubble_id_ex,
  output logic              bubble_mem_wb,
  output logic              pc_redirect,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  hz_state_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              redirect;
  logic              load_use;
  fwd_sel_t          fwd_a_sel, fwd_b_sel;

  // ---------------- forwarding ----------------
  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs            (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a_sel)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs            (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b_sel)
  );

  assign fwd_a = rst_n ? fwd_a_sel : FWD_RF;
  assign fwd_b = rst_n ? fwd_b_sel : FWD_RF;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (mem_req && !dmem_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ready)             state_nxt = RUN;
      default:                              state_nxt = RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A redirect seen during a freeze is not consumed; the ID/EX register is
  // held, so ex_redirect is still asserted when the freeze releases.
  always_comb begin
    freeze = rst_n && !dmem_ready && ((state == MEM_WAIT) || mem_req);
    redirect = rst_n && ex_redirect && !freeze;
    load_use = rst_n && !freeze && !ex_redirect && ex_mem_read &&
               (ex_rd != REG_AW'(REG_X0)) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));

    stall_pc      = freeze || load_use;
    stall_if_id   = freeze || load_use;
    stall_id_ex   = freeze;
    stall_ex_mem  = freeze;
    bubble_mem_wb = freeze;
    flush_if_id   = redirect;
    pc_redirect   = redirect;
    bubble_id_ex  = redirect || load_use;
  end

  // ---------------- memory-wait timeout ----------------
  // wait_cnt stops at TIMEOUT so it cannot wrap during a very long wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == MEM_WAIT && !dmem_ready) begin
      if (wait_cnt != WAIT_W'(TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WAIT_W'(TIMEOUT - 1)) mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // ---------------- performance counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc    && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_if_id && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed self-checking bench for hazard_ctrl.
// Small counter width and timeout make saturation and timeout reachable.
module tb_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Control vector: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
  //                  flush_if_id, bubble_id_ex, bubble_mem_wb, pc_redirect}
  localparam logic [7:0] C_NONE    = 8'b0000_0000;
  localparam logic [7:0] C_LOADUSE = 8'b1100_0100;
  localparam logic [7:0] C_REDIR   = 8'b0000_1101;
  localparam logic [7:0] C_FREEZE  = 8'b1111_0010;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic              mem_reg_write, mem_req, dmem_ready, wb_reg_write;
  logic              stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic              flush_if_id, bubble_id_ex, bubble_mem_wb, pc_redirect;
  logic [1:0]        fwd_a, fwd_b;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .ex_redirect   (ex_redirect),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_req       (mem_req),
    .dmem_ready    (dmem_ready),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .stall_pc      (stall_pc),
    .stall_if_id   (stall_if_id),
    .stall_id_ex   (stall_id_ex),
    .stall_ex_mem  (stall_ex_mem),
    .flush_if_id   (flush_if_id),
    .bubble_id_ex  (bubble_id_ex),
    .bubble_mem_wb (bubble_mem_wb),
    .pc_redirect   (pc_redirect),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .mem_timeout   (mem_timeout),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic [7:0] exp);
    #1;
    check(tag, {24'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                flush_if_id, bubble_id_ex, bubble_mem_wb, pc_redirect}, {24'd0, exp});
  endtask

  // Advance one clock; st/fl state whether this cycle should count a stall/flush.
  task automatic tick(input string tag, input bit st, input bit fl);
    if (st && exp_stall < CNT_MAX) exp_stall++;
    if (fl && exp_flush < CNT_MAX) exp_flush++;
    @(posedge clk);
    #1;
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
  endtask

  task automatic clear_ins();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect} = '0;
    {mem_reg_write, mem_req, dmem_ready, wb_reg_write} = '0;
  endtask

  initial begin
    clear_ins();
    rst_n = 1'b0;
    // Active-looking inputs during reset must not reach the outputs.
    mem_req = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd3; ex_rs1 = 5'd3;
    #3;
    check_ctrl("rst.ctrl", C_NONE);
    check("rst.fwd_a", 32'(fwd_a), 32'd0);
    check("rst.timeout", 32'(mem_timeout), 32'd0);
    check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst.flush_cnt", 32'(flush_cnt), 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_ctrl("idle.ctrl", C_NONE);
    check("idle.fwd_a_mem", 32'(fwd_a), 32'd2);
    clear_ins();

    // ---- load-use: lw x5 in EX, add x6,x5,x1 in ID ----
    tick("t0", 0, 0);
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd1;
    check_ctrl("lu.rs1", C_LOADUSE);
    tick("lu1", 1, 0);
    ex_mem_read = 1'b0; ex_rd = 5'd0;        // bubble now in EX
    check_ctrl("lu.cleared", C_NONE);
    tick("lu2", 0, 0);

    // ---- x0 destination and unused operand ----
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    check_ctrl("lu.x0", C_NONE);
    ex_rd = 5'd5; id_rs1 = 5'd2; id_rs2 = 5'd5; id_use_rs2 = 1'b0;
    check_ctrl("lu.rs2_unused", C_NONE);
    id_use_rs2 = 1'b1;
    check_ctrl("lu.rs2_used", C_LOADUSE);
    tick("lu3", 1, 0);
    clear_ins();

    // ---- forwarding ----
    mem_rd = 5'd0; mem_reg_write = 1'b1; ex_rs1 = 5'd0;
    #1 check("fwd.x0", 32'(fwd_a), 32'd0);
    mem_rd = 5'd7; wb_rd = 5'd7; wb_reg_write = 1'b1; ex_rs1 = 5'd7; ex_rs2 = 5'd7;
    #1 check("fwd_a.mem_prio", 32'(fwd_a), 32'd2);
    check("fwd_b.mem_prio", 32'(fwd_b), 32'd2);
    mem_reg_write = 1'b0;
    #1 check("fwd_a.wb", 32'(fwd_a), 32'd1);
    ex_rs2 = 5'd8;
    #1 check("fwd_b.none", 32'(fwd_b), 32'd0);
    clear_ins();

    // ---- redirect beats load-use ----
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
    check_ctrl("redir.over_lu", C_REDIR);
    tick("redir", 0, 1);
    clear_ins();

    // ---- memory wait with a pending redirect ----
    mem_req = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_ctrl($sformatf("wait.freeze%0d", i), C_FREEZE);
      tick("wait", 1, 0);
    end
    dmem_ready = 1'b1;
    check_ctrl("wait.release", C_REDIR);
    tick("wait.rel", 0, 1);
    clear_ins();
    check_ctrl("wait.back_run", C_NONE);
    check("wait.no_timeout", 32'(mem_timeout), 32'd0);

    // ---- zero-wait access ----
    mem_req = 1'b1; dmem_ready = 1'b1;
    check_ctrl("zw.no_stall", C_NONE);
    tick("zw", 0, 0);
    clear_ins();
    check_ctrl("zw.still_run", C_NONE);

    // ---- timeout: flag rises after the 4th MEM_WAIT cycle and sticks ----
    mem_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      check_ctrl($sformatf("to.freeze%0d", i), C_FREEZE);
      tick("to", 1, 0);                       // stall_cnt saturates here
      check($sformatf("to.flag%0d", i), 32'(mem_timeout), (i >= 5) ? 32'd1 : 32'd0);
    end
    dmem_ready = 1'b1;
    check_ctrl("to.release", C_NONE);
    tick("to.rel", 0, 0);
    clear_ins();
    check("to.sticky", 32'(mem_timeout), 32'd1);

    // ---- flush counter saturation ----
    ex_redirect = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check_ctrl("sat.redir", C_REDIR);
      tick("sat", 0, 1);
    end
    clear_ins();

    // ---- reset in the middle of a wait with a pending redirect ----
    mem_req = 1'b1; ex_redirect = 1'b1;
    tick("pre_rst", 1, 0);
    mem_reg_write = 1'b1; mem_rd = 5'd9; ex_rs1 = 5'd9; ex_rs2 = 5'd9;
    #1 rst_n = 1'b0;
    check_ctrl("rst2.ctrl", C_NONE);
    check("rst2.fwd_a", 32'(fwd_a), 32'd0);
    check("rst2.fwd_b", 32'(fwd_b), 32'd0);
    check("rst2.timeout", 32'(mem_timeout), 32'd0);
    check("rst2.stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst2.flush_cnt", 32'(flush_cnt), 32'd0);
    clear_ins();
    exp_stall = 0;
    exp_flush = 0;
    #2 rst_n = 1'b1;
    check_ctrl("rst2.run_no_redir", C_NONE);
    tick("post_rst", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the bench never hangs.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core. It generates the per-stage stall, flush and bubble controls and the EX-stage operand forwarding selects.
- It detects load-use hazards, flushes on taken branches and jumps resolved in EX, and freezes the pipeline while the data memory handshake is pending.
- It keeps a memory-wait timeout flag and saturating stall and flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, performance counter width.
- TIMEOUT, 255, number of MEM_WAIT cycles before mem_timeout is set.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  REG_AW each  source registers of the instruction in ID (IF/ID register).
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_rs1, ex_rs2  in  REG_AW each  source registers in EX (ID/EX register).
- ex_rd  in  REG_AW  destination register in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_redirect  in  1  taken branch, jal or jalr resolved in EX.
- mem_rd  in  REG_AW  destination register in MEM (EX/MEM register).
- mem_reg_write  in  1  MEM instruction writes the register file.
- mem_req  in  1  MEM stage issues a data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- wb_rd  in  REG_AW  destination register in WB (MEM/WB register).
- wb_reg_write  in  1  WB instruction writes the register file.
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold the PC / pipeline register.
- flush_if_id  out  1  replace the IF/ID content with a NOP.
- bubble_id_ex, bubble_mem_wb  out  1 each  insert a NOP into that register.
- pc_redirect  out  1  PC mux selects the EX target.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 WB value, 10 MEM value.
- mem_timeout  out  1  sticky error flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Behaviour:
- Reset: async, active-low. State=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0. While rst_n=0 all control outputs and fwd_a/fwd_b are 0.
- FSM states: RUN and MEM_WAIT.
- RUN -> MEM_WAIT when mem_req=1 and dmem_ready=0.
- MEM_WAIT -> RUN on the first cycle dmem_ready=1.
- A zero-wait access (mem_req=1 and dmem_ready=1 in the same cycle) stays in RUN and causes no stall.
- MEM freeze (combinational): active when state is MEM_WAIT with dmem_ready=0, or state is RUN with mem_req=1 and dmem_ready=0.
  - Outputs: stall_pc, stall_if_id, stall_id_ex and stall_ex_mem=1, bubble_mem_wb=1.
  - pc_redirect, flush_if_id and bubble_id_ex are forced to 0. An EX redirect pending during the freeze is held in ID/EX and takes effect in the cycle the freeze releases.
- Redirect: ex_redirect=1 and no freeze gives pc_redirect=1, flush_if_id=1 and bubble_id_ex=1 for that cycle. Redirect has priority over load-use: no stall is asserted in that cycle.
- Load-use hazard: ex_mem_read=1, ex_rd!=0, and either (id_use_rs1=1 and id_rs1==ex_rd) or (id_use_rs2=1 and id_rs2==ex_rd), with no freeze and no redirect.
  - Response: stall_pc=1, stall_if_id=1, bubble_id_ex=1 for one cycle. The hazard clears naturally on the next cycle.
- Forwarding, fwd_a shown (fwd_b is identical using ex_rs2):
  - 10 if mem_reg_write=1, mem_rd!=0 and mem_rd==ex_rs1.
  - Otherwise 01 if wb_reg_write=1, wb_rd!=0 and wb_rd==ex_rs1.
  - Otherwise 00.
  - MEM has priority over WB. Register x0 is never forwarded.
- Timeout counter:
  - wait_cnt increments every cycle in MEM_WAIT and clears on leaving MEM_WAIT.
  - When wait_cnt==TIMEOUT-1 while still waiting, mem_timeout is set. It stays set until reset.
  - The pipeline keeps waiting; the flag does not abort the access.
- Performance counters:
  - stall_cnt +1 on every cycle with stall_pc=1.
  - flush_cnt +1 on every cycle with flush_if_id=1.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-wait: immediate return to RUN with all counters and flags cleared. No pending redirect is remembered.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef fwd_sel_t: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - typedef hz_state_t: RUN, MEM_WAIT.
  - constant REG_X0=0.
- One sub-module, fwd_unit: the combinational forwarding comparator, instantiated once per operand.
- The FSM, hazard priority logic and counters live in hazard_ctrl.

Test Plan:
- Load-use: lw x5 in EX (ex_mem_read=1, ex_rd=5), add x6,x5,x1 in ID (id_rs1=5, id_use_rs1=1) -> exactly one cycle of stall_pc=1, stall_if_id=1, bubble_id_ex=1; stall_cnt goes 0 -> 1.
- x0 and unused operands:
  - ex_rd=0 with a load in EX -> no stall.
  - id_rs2==ex_rd with id_use_rs2=0 -> no stall.
  - mem_rd=0, mem_reg_write=1, ex_rs1=0 -> fwd_a=00.
- Forward priority: mem_rd=wb_rd=7, both writes=1, ex_rs1=7 -> fwd_a=10; drop mem_reg_write -> fwd_a=01.
- Redirect with simultaneous load-use condition -> pc_redirect=1, flush_if_id=1, bubble_id_ex=1, stall_pc=0; flush_cnt +1.
- Memory wait: mem_req=1 with dmem_ready low for 3 cycles, ex_redirect=1 throughout -> 3 cycles of all stalls and bubble_mem_wb=1, pc_redirect=0; on the cycle dmem_ready=1 -> pc_redirect=1 and state returns to RUN.
- Timeout and reset: with TIMEOUT=4, dmem_ready held low for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays high; pulsing rst_n low -> all outputs 0, state RUN, counters 0.
